// File: rtl/rns_rc_pkg.sv
// Shared definitions for the 129/128/127 residue-to-binary converter:
// FSM state encoding and the moduli/range constants.
package rns_rc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD1 = 3'd1,
        ST_SUB  = 3'd2,
        ST_ADD2 = 3'd3,
        ST_DONE = 3'd4
    } rc_state_e;

    localparam int unsigned M1    = 129;
    localparam int unsigned M2    = 128;
    localparam int unsigned M3    = 127;
    localparam int unsigned MOD14 = 16383;
    localparam int unsigned XMAX  = 2097023;

    // width of the high part of X (everything above the mod-128 residue)
    localparam int unsigned T_W   = 14;

endpackage

// File: rtl/mod16383_add.sv
// Combinational end-around-carry adder modulo 2^14-1. The +1 sum decides
// whether the carry wraps, which keeps 16383 from appearing as a result
// unless both operands are already 16383.
module mod16383_add
    import rns_rc_pkg::*;
(
    input  logic [T_W-1:0] p_i,
    input  logic [T_W-1:0] q_i,
    output logic [T_W-1:0] s_o
);

    logic [T_W-1:0] sum;
    logic [T_W:0]   sum_inc;

    assign sum     = p_i + q_i;
    assign sum_inc = {1'b0, p_i} + {1'b0, q_i} + {{T_W{1'b0}}, 1'b1};
    assign s_o     = sum_inc[T_W] ? sum_inc[T_W-1:0] : sum;

endmodule

// File: rtl/rns_rc_sched_129_128_127.sv
// Residue {129,128,127} to binary converter. One mod-16383 adder and one
// 14-bit subtractor are time-shared over three cycles; the result is
// X = {t3, x2}. Optional input range flag is built only when
// RNS_RC_RANGE_CHECK_EN is defined; otherwise out_err is tied low.
//
//   state | meaning
//   IDLE  | waiting for a residue triple
//   ADD1  | t1 = a2 (+) a3
//   SUB   | t2 = a1 - x1 mod 2^14
//   ADD2  | t3 = t1 (+) t2
//   DONE  | result presented until taken; may accept the next triple
module rns_rc_sched_129_128_127
    import rns_rc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       x1,
    input  logic [6:0]       x2,
    input  logic [6:0]       x3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [20:0]      out,
    output logic             out_err,
    output logic [CNT_W-1:0] conv_count
);

    rc_state_e        state_q, state_d;
    logic [7:0]       x1_q;
    logic [6:0]       x2_q, x3_q;
    logic [T_W-1:0]   t1_q, t2_q, t3_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             retire;
    logic             bx;
    logic [T_W-1:0]   a1, a2, a3;
    logic [T_W-1:0]   sub_res;
    logic [T_W-1:0]   add_p, add_q, add_s;

    // in_ready is gated by rst_n so nothing is offered while reset is held
    assign in_ready  = rst_n && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign retire    = out_valid && out_ready;

    assign bx      = x1_q[7] ^ x1_q[0];
    assign a1      = {bx, x1_q[6:1], bx, x1_q[6:1]};
    assign a2      = {~x2_q, 7'h7F};
    assign a3      = {x3_q[0], x3_q[6:1], x3_q[0], x3_q[6:1]};
    assign sub_res = a1 - {6'd0, x1_q};

    // shared adder operands: coefficients in ADD1, partial sums otherwise
    always_comb begin
        add_p = t1_q;
        add_q = t2_q;
        if (state_q == ST_ADD1) begin
            add_p = a2;
            add_q = a3;
        end
    end

    mod16383_add u_add (
        .p_i (add_p),
        .q_i (add_q),
        .s_o (add_s)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: fixed three-step walk, DONE waits for the consumer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_ADD1;
            ST_ADD1: state_d = ST_SUB;
            ST_SUB:  state_d = ST_ADD2;
            ST_ADD2: state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = accept ? ST_ADD1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // operand capture and per-step result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_q <= '0;
            x2_q <= '0;
            x3_q <= '0;
            t1_q <= '0;
            t2_q <= '0;
            t3_q <= '0;
        end else begin
            if (accept) begin
                x1_q <= x1;
                x2_q <= x2;
                x3_q <= x3;
            end
            if (state_q == ST_ADD1) t1_q <= add_s;
            if (state_q == ST_SUB)  t2_q <= sub_res;
            if (state_q == ST_ADD2) t3_q <= add_s;
        end
    end

    // retired-result counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out        = {t3_q, x2_q};
    assign conv_count = cnt_q;

`ifdef RNS_RC_RANGE_CHECK_EN
    logic err_q;

    // flag residues outside their modulus at accept time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= (x1 > 8'd128) || (x3 == 7'd127);
        end
    end

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_rns_rc_sched_129_128_127.sv
module tb_rns_rc_sched_129_128_127;
    import rns_rc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  x1;
    logic [6:0]  x2, x3;

    logic        in_ready, out_valid, out_err;
    logic [20:0] out_w;
    logic [15:0] cnt16;

    logic        in_ready4, out_valid4, out_err4;
    logic [20:0] out_w4;
    logic [3:0]  cnt4;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_count = 0;

`ifdef RNS_RC_RANGE_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    rns_rc_sched_129_128_127 #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .x3(x3), .out_valid(out_valid), .out_ready(out_ready),
        .out(out_w), .out_err(out_err), .conv_count(cnt16)
    );

    rns_rc_sched_129_128_127 #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .x1(x1), .x2(x2), .x3(x3), .out_valid(out_valid4), .out_ready(out_ready),
        .out(out_w4), .out_err(out_err4), .conv_count(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  x1;
        logic [6:0]  x2;
        logic [6:0]  x3;
        logic [20:0] exp_out;
        logic        chk_out;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // CRT reference: the unique X in [0, 129*128*127) with the given residues
    function automatic int crt(input int r1, input int r2, input int r3);
        int res;
        int x;
        res = -1;
        for (int k = 0; k < int'(MOD14); k++) begin
            x = r2 + int'(M2) * k;
            if (res < 0 && (x % int'(M1)) == r1 && (x % int'(M3)) == r3) res = x;
        end
        return res;
    endfunction

    // one full conversion with out_ready held high
    task automatic run_one(input logic [7:0] a, input logic [6:0] b, input logic [6:0] c,
                           input logic [20:0] exp_out, input logic chk_out,
                           input logic exp_err, input string name);
        int guard;
        int lat;
        x1 = a; x2 = b; x3 = c;
        in_valid = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        chk({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({name, " in_ready4"}, {31'd0, in_ready4}, 32'd1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({name, " latency"}, lat, 32'd4);
        if (chk_out) begin
            chk({name, " out"}, {11'd0, out_w}, {11'd0, exp_out});
            chk({name, " out4"}, {11'd0, out_w4}, {11'd0, exp_out});
        end
        chk({name, " out_err"}, {31'd0, out_err}, {31'd0, exp_err});
        chk({name, " out_err4"}, {31'd0, out_err4}, {31'd0, exp_err});
        step();
        exp_count++;
        chk({name, " conv_count"}, {16'd0, cnt16}, exp_count & 32'hFFFF);
        chk({name, " conv_count4"}, {28'd0, cnt4}, exp_count % 16);
    endtask

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  bx1[3];
        logic [6:0]  bx2[3];
        logic [6:0]  bx3[3];
        logic [20:0] bexp[3];
        logic [20:0] hold_exp;
        int          e;
        logic [7:0]  ra;
        logic [6:0]  rb, rc;

        vecs[0] = '{8'd0,   7'd0,   7'd0,   21'd0,       1'b1, 1'b0};
        vecs[1] = '{8'd1,   7'd1,   7'd1,   21'd1,       1'b1, 1'b0};
        vecs[2] = '{8'd128, 7'd0,   7'd1,   21'd128,     1'b1, 1'b0};
        vecs[3] = '{8'd128, 7'd127, 7'd126, 21'd2097023, 1'b1, 1'b0};
        vecs[4] = '{8'd2,   7'd0,   7'd0,   21'd16256,   1'b1, 1'b0};
        vecs[5] = '{8'd0,   7'd0,   7'd1,   21'd1056768, 1'b1, 1'b0};
        vecs[6] = '{8'd129, 7'd1,   7'd1,   21'd0,       1'b0, ERR_ON};
        vecs[7] = '{8'd1,   7'd1,   7'd127, 21'd0,       1'b0, ERR_ON};

        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x1 = '0; x2 = '0; x3 = '0;
        #2;
        rst_n = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out", {11'd0, out_w}, 32'd0);
        chk("reset out_err", {31'd0, out_err}, 32'd0);
        chk("reset conv_count", {16'd0, cnt16}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd0);
        step();
        step();
        chk("reset held in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("idle in_ready", {31'd0, in_ready}, 32'd1);

        // single zero triple
        run_one(8'd0, 7'd0, 7'd0, 21'd0, 1'b1, 1'b0, "zero");

        // table vectors
        for (int i = 0; i < 8; i++)
            run_one(vecs[i].x1, vecs[i].x2, vecs[i].x3, vecs[i].exp_out,
                    vecs[i].chk_out, vecs[i].exp_err, $sformatf("vec%0d", i));

        // back-to-back with junk offered while busy
        bx1[0] = 8'd1;   bx2[0] = 7'd1;   bx3[0] = 7'd1;   bexp[0] = 21'd1;
        bx1[1] = 8'd128; bx2[1] = 7'd0;   bx3[1] = 7'd1;   bexp[1] = 21'd128;
        bx1[2] = 8'd128; bx2[2] = 7'd127; bx3[2] = 7'd126; bexp[2] = 21'd2097023;
        out_ready = 1'b1;
        x1 = bx1[0]; x2 = bx2[0]; x3 = bx3[0];
        in_valid = 1'b1;
        chk("b2b first in_ready", {31'd0, in_ready}, 32'd1);
        step();
        for (int i = 0; i < 3; i++) begin
            x1 = 8'd77; x2 = 7'd99; x3 = 7'd5;
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("b2b%0d busy in_ready", i), {31'd0, in_ready}, 32'd0);
                chk($sformatf("b2b%0d busy out_valid", i), {31'd0, out_valid}, 32'd0);
                step();
            end
            chk($sformatf("b2b%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("b2b%0d out", i), {11'd0, out_w}, {11'd0, bexp[i]});
            chk($sformatf("b2b%0d done in_ready", i), {31'd0, in_ready}, 32'd1);
            if (i < 2) begin
                x1 = bx1[i+1]; x2 = bx2[i+1]; x3 = bx3[i+1];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            exp_count++;
        end
        chk("b2b conv_count", {16'd0, cnt16}, exp_count & 32'hFFFF);
        chk("b2b idle out_valid", {31'd0, out_valid}, 32'd0);

        // consumer stall in DONE
        hold_exp = 21'(crt(3, 4, 5));
        x1 = 8'd3; x2 = 7'd4; x3 = 7'd5;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        x1 = 8'd60; x2 = 7'd61; x3 = 7'd62;
        step(); step(); step();
        for (int i = 0; i < 10; i++) begin
            chk("hold out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold out", {11'd0, out_w}, {11'd0, hold_exp});
            chk("hold in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        chk("hold conv_count", {16'd0, cnt16}, exp_count & 32'hFFFF);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("hold release in_ready", {31'd0, in_ready}, 32'd1);
        step();
        exp_count++;
        chk("hold retire out_valid", {31'd0, out_valid}, 32'd0);
        chk("hold retire conv_count", {16'd0, cnt16}, exp_count & 32'hFFFF);
        step();
        chk("hold single retire", {16'd0, cnt16}, exp_count & 32'hFFFF);

        // reset pulsed during SUB
        x1 = 8'd5; x2 = 7'd5; x3 = 7'd5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst out", {11'd0, out_w}, 32'd0);
        chk("midrst out_err", {31'd0, out_err}, 32'd0);
        chk("midrst conv_count", {16'd0, cnt16}, 32'd0);
        chk("midrst in_ready", {31'd0, in_ready}, 32'd0);
        step();
        step();
        in_valid = 1'b0;
        rst_n = 1'b1;
        exp_count = 0;
        e = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) e++;
            step();
        end
        chk("midrst no stale out_valid", e, 32'd0);
        run_one(8'd1, 7'd1, 7'd1, 21'd1, 1'b1, 1'b0, "after_rst");

        // random valid triples vs CRT; 17th retirement wraps the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom_range(0, 128));
            rb = 7'($urandom_range(0, 127));
            rc = 7'($urandom_range(0, 126));
            run_one(ra, rb, rc, 21'(crt(int'(ra), int'(rb), int'(rc))), 1'b1, 1'b0,
                    $sformatf("rnd%0d", i));
        end
        chk("wrap conv_count4", {28'd0, cnt4}, 32'd1);
        chk("wrap conv_count16", {16'd0, cnt16}, 32'd17);

        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom_range(0, 128));
            rb = 7'($urandom_range(0, 127));
            rc = 7'($urandom_range(0, 126));
            run_one(ra, rb, rc, 21'(crt(int'(ra), int'(rb), int'(rc))), 1'b1, 1'b0,
                    $sformatf("rndb%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rns_rc_sched_129_128_127.md
RNS_RC_SCHED_129_128_127 -- requirements
Module: rns_rc_sched_129_128_127

Interface
REQ-001 Parameter CNT_W, default 16: width of the completed-conversion counter.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  residue triple present.
REQ-005 in_ready  output  1  block accepts the triple this cycle.
REQ-006 x1  input  8  residue mod 129.
REQ-007 x2  input  7  residue mod 128.
REQ-008 x3  input  7  residue mod 127.
REQ-009 out_valid  output  1  result present, held until taken.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 out  output  21  binary value X, 0..2097023.
REQ-012 out_err  output  1  input triple was out of range (see Configuration).
REQ-013 conv_count  output  CNT_W  number of results retired.

Function
REQ-014 The block shall time-share one mod-16383 adder and one 14-bit subtractor across the three conversion steps, sequenced by an FSM: IDLE, ADD1, SUB, ADD2, DONE.
REQ-015 Accept shall occur when in_valid && in_ready; x1/x2/x3 are registered and the FSM moves to ADD1.
REQ-016 Coefficients from the registered residues:
- bx = x1[7]^x1[0]
- a1 = {bx, x1[6:1], bx, x1[6:1]}
- a2 = {~x2, 7'h7F}
- a3 = {x3[0], x3[6:1], x3[0], x3[6:1]}
REQ-017 Modular add rule: s = (p+q+1)[13:0] if (p+q+1) carries out of bit 13, else (p+q)[13:0].
REQ-018 Steps, one per cycle:
- ADD1: t1 = a2 (+) a3
- SUB: t2 = (a1 - x1) mod 2^14
- ADD2: t3 = t1 (+) t2
REQ-019 In DONE, out = {t3, x2} and out_valid=1; latency is accept cycle + 4 edges.
REQ-020 in_ready shall be 1 in IDLE, 1 in DONE when out_ready=1, and 0 otherwise.
REQ-021 DONE with out_ready=1 and no accept shall return to IDLE; with a simultaneous accept it shall go directly to ADD1 (back-to-back, one result per 4 cycles).
REQ-022 DONE with out_ready=0 shall hold out, out_err and out_valid stable.
REQ-023 conv_count shall increment on each out_valid && out_ready and wrap from 2^CNT_W-1 to 0.
REQ-024 in_valid in ADD1/SUB/ADD2 shall be ignored (in_ready=0); no input is lost or overwritten.

Reset
REQ-025 rst_n=0 shall immediately force:
- state to IDLE
- out_valid=0, out=0, out_err=0, conv_count=0
- in_ready=0 while asserted
REQ-026 Reset mid-conversion shall discard the triple; the first accept after release restarts cleanly.

Configuration
REQ-027 With RNS_RC_RANGE_CHECK_EN defined, accept shall latch err = (x1>128) || (x3==127) and present it as out_err alongside out; the conversion still runs.
REQ-028 Without RNS_RC_RANGE_CHECK_EN, out_err shall be constant 0 and no comparison logic is built.

Structure
REQ-029 Shared package rns_rc_pkg shall hold:
- FSM state enum
- constants M1=129, M2=128, M3=127, MOD14=16383, XMAX=2097023
REQ-030 Sub-module mod16383_add implements REQ-017 combinationally and is instantiated exactly once.

Verification
REQ-031 Residues (0,0,0), out_ready=1 -> out=0, out_valid 4 edges after accept, conv_count=1.
REQ-032 Triples (1,1,1), then (128,0,1), then (128,127,126) back-to-back -> out = 1, 128, 2097023; one result per 4 cycles; in_ready high in each DONE.
REQ-033 Hold out_ready=0 for 10 cycles in DONE -> out stable, in_ready=0, new in_valid ignored; on out_ready=1 retire once.
REQ-034 rst_n pulsed low during SUB -> outputs zero immediately, no out_valid for that triple, next triple (1,1,1) gives out=1.
REQ-035 With RNS_RC_RANGE_CHECK_EN: x1=129 -> out_err=1; x3=127 -> out_err=1; (1,1,1) -> out_err=0. Without the macro, out_err=0 for all three.
REQ-036 CNT_W=4, 17 retirements -> conv_count wraps to 1.
